// File: rtl/exception_ctrl_mi_pkg.sv
// Shared types and constants for the multi-issue precise-exception controller:
// ExcCodes, per-slot flag layout, vector constants and the captured-event record.
package exception_ctrl_mi_pkg;

  typedef enum logic [4:0] {
    CODE_INT  = 5'h00,
    CODE_MOD  = 5'h01,
    CODE_TLBL = 5'h02,
    CODE_TLBS = 5'h03,
    CODE_ADEL = 5'h04,
    CODE_ADES = 5'h05,
    CODE_SYS  = 5'h08,
    CODE_BP   = 5'h09,
    CODE_RI   = 5'h0A,
    CODE_OV   = 5'h0C
  } exc_code_t;

  // Flag bit order matches slot priority: lower index wins.
  localparam int unsigned EXC_FLAGS_W        = 12;
  localparam int unsigned FLAG_FETCH_ADEL    = 0;
  localparam int unsigned FLAG_ITLB_REFILL   = 1;
  localparam int unsigned FLAG_ITLB_INVALID  = 2;
  localparam int unsigned FLAG_RI            = 3;
  localparam int unsigned FLAG_OV            = 4;
  localparam int unsigned FLAG_BP            = 5;
  localparam int unsigned FLAG_SYS           = 6;
  localparam int unsigned FLAG_LOAD_ADEL     = 7;
  localparam int unsigned FLAG_STORE_ADES    = 8;
  localparam int unsigned FLAG_DTLB_REFILL   = 9;
  localparam int unsigned FLAG_DTLB_INVALID  = 10;
  localparam int unsigned FLAG_DTLB_MOD      = 11;

  localparam int unsigned PKG_VADDR_W = 32;

  localparam logic [PKG_VADDR_W-1:0] VEC_BASE_BEV    = 32'hBFC0_0200;
  localparam logic [PKG_VADDR_W-1:0] VEC_BASE_NORMAL = 32'h8000_0000;
  localparam logic [PKG_VADDR_W-1:0] VEC_OFS_REFILL  = 32'h0000_0000;
  localparam logic [PKG_VADDR_W-1:0] VEC_OFS_GENERAL = 32'h0000_0180;

  typedef enum logic [1:0] {
    BVA_NONE   = 2'd0,
    BVA_PC     = 2'd1,
    BVA_DVADDR = 2'd2
  } bva_sel_t;

  // target holds the vector base for exceptions and the return PC for ERET;
  // refill is set only when the refill offset applies (refill taken at EXL=0).
  typedef struct packed {
    exc_code_t              code;
    logic [PKG_VADDR_W-1:0] epc;
    logic                   bd;
    logic [PKG_VADDR_W-1:0] badvaddr;
    logic                   bva_we;
    logic                   refill;
    logic                   eret;
    logic                   epc_we;
    logic [PKG_VADDR_W-1:0] target;
  } exc_capture_t;

  function automatic logic [PKG_VADDR_W-1:0] vector_base(input logic bev);
    return bev ? VEC_BASE_BEV : VEC_BASE_NORMAL;
  endfunction

  function automatic logic [PKG_VADDR_W-1:0] vector_offset(input logic refill);
    return refill ? VEC_OFS_REFILL : VEC_OFS_GENERAL;
  endfunction

endpackage

// File: rtl/exception_ctrl_mi_if.sv
// Commit-slot, CP0 and fetch-redirect signal bundle for exception_ctrl_mi.
interface exception_ctrl_mi_if #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned INT_LINES   = 8,
  parameter int unsigned VADDR_W     = 32
) ();
  import exception_ctrl_mi_pkg::*;

  logic [ISSUE_WIDTH-1:0]             slot_valid;
  logic [ISSUE_WIDTH*VADDR_W-1:0]     slot_pc;
  logic [ISSUE_WIDTH-1:0]             slot_bd;
  logic [ISSUE_WIDTH*EXC_FLAGS_W-1:0] slot_flags;
  logic [ISSUE_WIDTH-1:0]             slot_is_store;
  logic [ISSUE_WIDTH*VADDR_W-1:0]     slot_dvaddr;
  logic [ISSUE_WIDTH-1:0]             slot_eret;
  logic [INT_LINES-1:0]               int_req;
  logic                               status_ie;
  logic                               status_exl;
  logic                               status_erl;
  logic                               status_bev;
  logic [VADDR_W-1:0]                 cp0_epc_cur;

  logic                               commit_stall;
  logic [ISSUE_WIDTH-1:0]             slot_kill;
  logic                               redirect_valid;
  logic [VADDR_W-1:0]                 redirect_pc;
  logic                               redirect_ready;

  logic                               cp0_exc_we;
  logic                               cp0_epc_we;
  logic                               cp0_bva_we;
  logic                               cp0_eret_we;
  logic [4:0]                         cp0_code;
  logic [VADDR_W-1:0]                 cp0_epc;
  logic                               cp0_bd;
  logic [VADDR_W-1:0]                 cp0_badvaddr;

  modport master (
    output slot_valid, slot_pc, slot_bd, slot_flags, slot_is_store, slot_dvaddr,
           slot_eret, int_req, status_ie, status_exl, status_erl, status_bev,
           cp0_epc_cur, redirect_ready,
    input  commit_stall, slot_kill, redirect_valid, redirect_pc,
           cp0_exc_we, cp0_epc_we, cp0_bva_we, cp0_eret_we,
           cp0_code, cp0_epc, cp0_bd, cp0_badvaddr
  );

  modport slave (
    input  slot_valid, slot_pc, slot_bd, slot_flags, slot_is_store, slot_dvaddr,
           slot_eret, int_req, status_ie, status_exl, status_erl, status_bev,
           cp0_epc_cur, redirect_ready,
    output commit_stall, slot_kill, redirect_valid, redirect_pc,
           cp0_exc_we, cp0_epc_we, cp0_bva_we, cp0_eret_we,
           cp0_code, cp0_epc, cp0_bd, cp0_badvaddr
  );
endinterface

// File: rtl/exception_ctrl_mi_prio_enc.sv
// Per-slot exception priority encoder: picks the highest-priority flag of one
// commit slot and reports its ExcCode, refill class and BadVAddr source.
module exception_prio_enc
  import exception_ctrl_mi_pkg::*;
(
  input  logic [EXC_FLAGS_W-1:0] flags,
  input  logic                   is_store,
  output logic                   hit,
  output exc_code_t              code,
  output logic                   refill,
  output bva_sel_t               bva_sel
);

  always_comb begin
    hit     = 1'b1;
    code    = CODE_INT;
    refill  = 1'b0;
    bva_sel = BVA_NONE;
    if (flags[FLAG_FETCH_ADEL]) begin
      code    = CODE_ADEL;
      bva_sel = BVA_PC;
    end else if (flags[FLAG_ITLB_REFILL] || flags[FLAG_ITLB_INVALID]) begin
      code    = CODE_TLBL;
      refill  = flags[FLAG_ITLB_REFILL];
      bva_sel = BVA_PC;
    end else if (flags[FLAG_RI]) begin
      code = CODE_RI;
    end else if (flags[FLAG_OV]) begin
      code = CODE_OV;
    end else if (flags[FLAG_BP]) begin
      code = CODE_BP;
    end else if (flags[FLAG_SYS]) begin
      code = CODE_SYS;
    end else if (flags[FLAG_LOAD_ADEL]) begin
      code    = CODE_ADEL;
      bva_sel = BVA_DVADDR;
    end else if (flags[FLAG_STORE_ADES]) begin
      code    = CODE_ADES;
      bva_sel = BVA_DVADDR;
    end else if (flags[FLAG_DTLB_REFILL] || flags[FLAG_DTLB_INVALID]) begin
      code    = is_store ? CODE_TLBS : CODE_TLBL;
      refill  = flags[FLAG_DTLB_REFILL];
      bva_sel = BVA_DVADDR;
    end else if (flags[FLAG_DTLB_MOD]) begin
      code    = CODE_MOD;
      bva_sel = BVA_DVADDR;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl_mi.sv
// Multi-issue precise-exception controller: selects the oldest excepting/ERET/
// interrupted commit slot, kills it and younger slots, then redirects fetch and writes CP0.
module exception_ctrl_mi #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned INT_LINES   = 8,
  parameter int unsigned VADDR_W     = 32
) (
  input logic               clk,
  input logic               reset,
  exception_ctrl_mi_if.slave bus
);
  import exception_ctrl_mi_pkg::*;

  localparam int unsigned SLOT_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [INT_LINES-1:0] int_q;
  exc_capture_t         cap_q, cap_d;

  logic [ISSUE_WIDTH-1:0] hit;
  logic [ISSUE_WIDTH-1:0] refill;
  exc_code_t              code    [ISSUE_WIDTH];
  bva_sel_t               bva_sel [ISSUE_WIDTH];

  logic                   int_ok;
  logic                   ev_found, ev_int, ev_eret, seen_valid;
  logic [SLOT_W-1:0]      ev_slot;
  logic [ISSUE_WIDTH-1:0] kill_mask;
  logic [VADDR_W-1:0]     sel_pc, sel_dvaddr;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_enc
    exception_prio_enc u_enc (
      .flags    (bus.slot_flags[g*EXC_FLAGS_W +: EXC_FLAGS_W]),
      .is_store (bus.slot_is_store[g]),
      .hit      (hit[g]),
      .code     (code[g]),
      .refill   (refill[g]),
      .bva_sel  (bva_sel[g])
    );
  end

  assign int_ok = (|int_q) & bus.status_ie & ~bus.status_exl & ~bus.status_erl;

  // The interrupt rides on the first valid slot; otherwise the first valid slot
  // with an exception or ERET wins. Kill bits turn on from the event slot upward.
  always_comb begin
    ev_found   = 1'b0;
    ev_int     = 1'b0;
    ev_eret    = 1'b0;
    seen_valid = 1'b0;
    ev_slot    = '0;
    kill_mask  = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      if (!ev_found && bus.slot_valid[i]) begin
        if (int_ok && !seen_valid) begin
          ev_found = 1'b1;
          ev_int   = 1'b1;
          ev_slot  = SLOT_W'(i);
        end else if (hit[i]) begin
          ev_found = 1'b1;
          ev_slot  = SLOT_W'(i);
        end else if (bus.slot_eret[i]) begin
          ev_found = 1'b1;
          ev_eret  = 1'b1;
          ev_slot  = SLOT_W'(i);
        end
        seen_valid = 1'b1;
      end
      kill_mask[i] = ev_found;
    end
  end

  assign sel_pc     = bus.slot_pc[ev_slot*VADDR_W +: VADDR_W];
  assign sel_dvaddr = bus.slot_dvaddr[ev_slot*VADDR_W +: VADDR_W];

  always_comb begin
    cap_d        = '0;
    cap_d.eret   = ev_eret;
    cap_d.code   = ev_int ? CODE_INT : code[ev_slot];
    cap_d.bd     = bus.slot_bd[ev_slot];
    cap_d.epc    = PKG_VADDR_W'(bus.slot_bd[ev_slot] ? (sel_pc - VADDR_W'(4)) : sel_pc);
    cap_d.epc_we = ~bus.status_exl;
    if (!ev_int && !ev_eret) begin
      cap_d.refill = refill[ev_slot] & ~bus.status_exl;
      unique case (bva_sel[ev_slot])
        BVA_PC: begin
          cap_d.bva_we   = 1'b1;
          cap_d.badvaddr = PKG_VADDR_W'(sel_pc);
        end
        BVA_DVADDR: begin
          cap_d.bva_we   = 1'b1;
          cap_d.badvaddr = PKG_VADDR_W'(sel_dvaddr);
        end
        default: cap_d.bva_we = 1'b0;
      endcase
    end
    cap_d.target = ev_eret ? PKG_VADDR_W'(bus.cp0_epc_cur) : vector_base(bus.status_bev);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      int_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= bus.int_req;
      if (state_q == ST_IDLE && ev_found) begin
        cap_q <= cap_d;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.commit_stall   = 1'b0;
    bus.slot_kill      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.cp0_exc_we     = 1'b0;
    bus.cp0_epc_we     = 1'b0;
    bus.cp0_bva_we     = 1'b0;
    bus.cp0_eret_we    = 1'b0;
    bus.cp0_code       = '0;
    bus.cp0_epc        = '0;
    bus.cp0_bd         = 1'b0;
    bus.cp0_badvaddr   = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.slot_kill = kill_mask;
        if (ev_found) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        bus.commit_stall   = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = cap_q.eret ? VADDR_W'(cap_q.target)
                           : VADDR_W'(cap_q.target + vector_offset(cap_q.refill));
        bus.cp0_code       = cap_q.code;
        bus.cp0_epc        = VADDR_W'(cap_q.epc);
        bus.cp0_bd         = cap_q.bd;
        bus.cp0_badvaddr   = VADDR_W'(cap_q.badvaddr);
        if (bus.redirect_ready) begin
          bus.cp0_exc_we  = ~cap_q.eret;
          bus.cp0_epc_we  = ~cap_q.eret & cap_q.epc_we;
          bus.cp0_bva_we  = ~cap_q.eret & cap_q.bva_we;
          bus.cp0_eret_we = cap_q.eret;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
